fpdivsqrt_issue_ctrl: RTL

- Requester-side controller for scalar_fpdivsqrt.
- Buffers div/sqrt requests from the FP pipeline in a small FIFO and drives the unit's start valid/ready interface, with one operation in flight.
- Captures finish results into a response register and returns them with the request tag.
- Forwards pipeline flush to the unit.

---
 rtl/fpdivsqrt_issue_pkg.sv | 19 +
 rtl/fpdivsqrt_issue_ctrl_if.sv | 49 ++++
 rtl/fpdivsqrt_req_fifo.sv | 44 ++++
 rtl/fpdivsqrt_issue_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/fpdivsqrt_issue_pkg.sv
// fpdivsqrt_issue_pkg: request payload, controller states and rounding-mode codes
// shared by the div/sqrt issue controller.
package fpdivsqrt_issue_pkg;
    typedef struct packed {
        logic [2:0]  fp_format;
        logic        is_fdiv;
        logic [63:0] opa;
        logic [63:0] opb;
        logic [2:0]  rm;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;
endpackage

// File: rtl/fpdivsqrt_issue_ctrl_if.sv
// fpdivsqrt_issue_ctrl_if: request, unit start/finish and response handshakes
// of the issue controller; slave is the controller's view, master the environment's.
interface fpdivsqrt_issue_ctrl_if #(
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_W = 4
);
    logic                         flush_i;
    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [2:0]                   req_fp_format_i;
    logic                         req_is_fdiv_i;
    logic [63:0]                  req_opa_i;
    logic [63:0]                  req_opb_i;
    logic [2:0]                   req_rm_i;
    logic [TAG_W-1:0]             req_tag_i;
    logic                         start_valid_o;
    logic                         start_ready_i;
    logic [2:0]                   fp_format_o;
    logic                         is_fdiv_o;
    logic [63:0]                  opa_o;
    logic [63:0]                  opb_o;
    logic [2:0]                   rm_o;
    logic                         flush_o;
    logic                         finish_valid_i;
    logic                         finish_ready_o;
    logic [63:0]                  res_i;
    logic [4:0]                   fflags_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [63:0]                  rsp_res_o;
    logic [4:0]                   rsp_fflags_o;
    logic [TAG_W-1:0]             rsp_tag_o;
    logic                         busy_o;
    logic [$clog2(QUEUE_DEPTH):0] count_o;

    modport slave (
        input  flush_i, req_valid_i, req_fp_format_i, req_is_fdiv_i, req_opa_i, req_opb_i,
               req_rm_i, req_tag_i, start_ready_i, finish_valid_i, res_i, fflags_i, rsp_ready_i,
        output req_ready_o, start_valid_o, fp_format_o, is_fdiv_o, opa_o, opb_o, rm_o, flush_o,
               finish_ready_o, rsp_valid_o, rsp_res_o, rsp_fflags_o, rsp_tag_o, busy_o, count_o
    );

    modport master (
        output flush_i, req_valid_i, req_fp_format_i, req_is_fdiv_i, req_opa_i, req_opb_i,
               req_rm_i, req_tag_i, start_ready_i, finish_valid_i, res_i, fflags_i, rsp_ready_i,
        input  req_ready_o, start_valid_o, fp_format_o, is_fdiv_o, opa_o, opb_o, rm_o, flush_o,
               finish_ready_o, rsp_valid_o, rsp_res_o, rsp_fflags_o, rsp_tag_o, busy_o, count_o
    );
endinterface

// File: rtl/fpdivsqrt_req_fifo.sv
// fpdivsqrt_req_fifo: power-of-two request FIFO with synchronous clear; the caller
// guarantees no push when full and no pop when empty.
module fpdivsqrt_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (push && !clr) mem[wr_ptr] <= din;
endmodule

// File: rtl/fpdivsqrt_issue_ctrl.sv
// fpdivsqrt_issue_ctrl: queues div/sqrt requests and runs them one at a time through scalar_fpdivsqrt.
// Optional macro FPDIVSQRT_ISSUE_PERF_CNT_EN adds issue and request-stall counters.
module fpdivsqrt_issue_ctrl
    import fpdivsqrt_issue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst,
    fpdivsqrt_issue_ctrl_if.slave bus
`ifdef FPDIVSQRT_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] perf_issue_cnt_o,
    output logic [31:0] perf_stall_cyc_o
`endif
);
    localparam int W = $bits(req_t) + TAG_W;

    state_t           state, state_nxt;
    req_t             in_req, head_req;
    logic [TAG_W-1:0] head_tag, inflight_tag;
    logic [W-1:0]     head;
    logic             full, empty, push, pop, load;

    assign in_req = '{fp_format: bus.req_fp_format_i, is_fdiv: bus.req_is_fdiv_i,
                      opa: bus.req_opa_i, opb: bus.req_opb_i, rm: bus.req_rm_i};
    assign {head_req, head_tag} = head;

    assign push = bus.req_valid_i & ~full & ~bus.flush_i;
    assign pop  = bus.start_valid_o & bus.start_ready_i;
    assign load = bus.finish_valid_i & bus.finish_ready_o;

    assign bus.req_ready_o    = ~full;
    assign bus.flush_o        = bus.flush_i;
    assign bus.start_valid_o  = (state == ISSUE) & ~bus.flush_i;
    assign bus.finish_ready_o = (state == WAIT) & (~bus.rsp_valid_o | bus.rsp_ready_i);
    assign bus.busy_o         = ~empty | (state != IDLE) | bus.rsp_valid_o;
    // Operands are only driven while offered so they read 0 out of reset.
    assign {bus.fp_format_o, bus.is_fdiv_o, bus.opa_o, bus.opb_o, bus.rm_o} =
        (state == ISSUE) ? head_req : '0;

    fpdivsqrt_req_fifo #(.DEPTH(QUEUE_DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush_i),
        .push  (push),
        .pop   (pop),
        .din   ({in_req, bus.req_tag_i}),
        .dout  (head),
        .count (bus.count_o),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        if (bus.flush_i) state_nxt = IDLE;
        else if (state == IDLE) state_nxt = empty ? IDLE : ISSUE;
        else if (state == ISSUE) state_nxt = pop ? WAIT : ISSUE;
        else if (state == WAIT) state_nxt = load ? IDLE : WAIT;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state            <= IDLE;
            inflight_tag     <= '0;
            bus.rsp_valid_o  <= 1'b0;
            bus.rsp_res_o    <= '0;
            bus.rsp_fflags_o <= '0;
            bus.rsp_tag_o    <= '0;
        end else begin
            state <= state_nxt;
            if (pop) inflight_tag <= head_tag;
            if (bus.flush_i) bus.rsp_valid_o <= 1'b0;
            else if (load) begin
                bus.rsp_valid_o  <= 1'b1;
                bus.rsp_res_o    <= bus.res_i;
                bus.rsp_fflags_o <= bus.fflags_i;
                bus.rsp_tag_o    <= inflight_tag;
            end else if (bus.rsp_ready_i) bus.rsp_valid_o <= 1'b0;
        end

`ifdef FPDIVSQRT_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perf_issue_cnt_o <= '0;
            perf_stall_cyc_o <= '0;
        end else begin
            perf_issue_cnt_o <= perf_issue_cnt_o + 32'(pop);
            perf_stall_cyc_o <= perf_stall_cyc_o + 32'(bus.req_valid_i & full);
        end
`endif
endmodule
